cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_ctrl_ir_decode.sv | 37 +++
 rtl/cpu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cpu_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller.
// Holds the FSM state encoding, the opcode/op field values the decoder
// recognises, and the register-file write-data mux select encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWrImm,
    StGetA,
    StGetB,
    StExec,
    StWrReg,
    StHalt
  } state_e;

  // Opcode classes (IR[15:13])
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field (IR[12:11]) within each class
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Register-file write-data mux selects
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_MDATA = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

endpackage

// File: rtl/cpu_ctrl_ir_decode.sv
// ir_decode: combinational field extraction and immediate extension for the
// instruction register.
// Ports:
//   ir_i        instruction register contents
//   opcode_o    IR[15:13]      op_o  IR[12:11]
//   rn_o        IR[10:8]       rd_o  IR[7:5]
//   sh_o        IR[4:3]        rm_o  IR[2:0]
//   sximm5_o    sign-extended imm5
//   sximm8_o    imm8 sign- or zero-extended according to IMM8_SIGNED
module ir_decode #(
  parameter bit IMM8_SIGNED = 1'b1
) (
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];

  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

  logic imm8_fill;
  assign imm8_fill = IMM8_SIGNED ? ir_i[7] : 1'b0;
  assign sximm8_o  = {{8{imm8_fill}}, ir_i[7:0]};

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction register plus Moore sequencing FSM for a simple
// register/ALU datapath.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in, load, s      instruction word, IR load request, start
//   w                idle/ready (high only in WAIT)
//   readnum..write   datapath register-file / mux / strobe controls
//   sximm8, sximm5   extended immediates from the current IR
//   err              illegal-opcode flag
// Build option: define CPU_CTRL_ILLEGAL_TRAP_EN to trap illegal encodings in
// HALT with a sticky err; otherwise they retire as a NOP and err is 0.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter bit IMM8_SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic [1:0]  shift,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        err
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;

  ir_decode #(
    .IMM8_SIGNED(IMM8_SIGNED)
  ) u_ir_decode (
    .ir_i    (ir_q),
    .opcode_o(opcode),
    .op_o    (op),
    .rn_o    (rn),
    .rd_o    (rd),
    .sh_o    (sh),
    .rm_o    (rm),
    .sximm5_o(sximm5),
    .sximm8_o(sximm8)
  );

  // Capture only while idle so a running instruction keeps its fields.
  assign ir_d = (state_q == StWait && load) ? in : ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWait;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic err_q, err_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    shift    = 2'b00;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    err_d    = err_q;
`endif

    unique case (state_q)
      StWait: begin
        w = 1'b1;
        if (s) state_d = StDecode;
      end
      StDecode: begin
        if (opcode == OPC_MOV && op == OP_MOV_IMM) begin
          state_d = StWrImm;
        end else if ((opcode == OPC_MOV && op == OP_MOV_REG) ||
                     (opcode == OPC_ALU && op == OP_MVN)) begin
          // Single-operand instructions skip the A read.
          state_d = StGetB;
        end else if (opcode == OPC_ALU) begin
          state_d = StGetA;
        end else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          state_d = StHalt;
          err_d   = 1'b1;
`else
          state_d = StWait;
`endif
        end
      end
      StWrImm: begin
        write    = 1'b1;
        vsel     = VSEL_IMM8;
        writenum = rn;
        state_d  = StWait;
      end
      StGetA: begin
        loada   = 1'b1;
        readnum = rn;
        state_d = StGetB;
      end
      StGetB: begin
        loadb   = 1'b1;
        readnum = rm;
        state_d = StExec;
      end
      StExec: begin
        shift = sh;
        loadc = 1'b1;
        if (opcode == OPC_ALU) begin
          ALUop = op;
        end else begin
          // MOV Rd,Rm: zero the A operand and pass B through the adder.
          asel  = 1'b1;
          ALUop = 2'b00;
        end
        if (opcode == OPC_ALU && op == OP_CMP) begin
          loads   = 1'b1;
          state_d = StWait;
        end else begin
          state_d = StWrReg;
        end
      end
      StWrReg: begin
        write    = 1'b1;
        vsel     = VSEL_C;
        writenum = rd;
        state_d  = StWait;
      end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StWait;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl. A second instance with
// IMM8_SIGNED=0 shares the inputs to check zero-extension of imm8.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = 16'h0000;
  logic        load = 1'b0;
  logic        s = 1'b0;

  logic        w, loada, loadb, asel, bsel, loadc, loads, write, err;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  logic        w_u, loada_u, loadb_u, asel_u, bsel_u, loadc_u, loads_u, write_u, err_u;
  logic [2:0]  readnum_u, writenum_u;
  logic [1:0]  vsel_u, shift_u, ALUop_u;
  logic [15:0] sximm8_u, sximm5_u;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_ctrl #(.IMM8_SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .vsel(vsel), .loada(loada),
    .loadb(loadb), .shift(shift), .asel(asel), .bsel(bsel), .ALUop(ALUop),
    .loadc(loadc), .loads(loads), .write(write), .sximm8(sximm8),
    .sximm5(sximm5), .err(err)
  );

  cpu_ctrl #(.IMM8_SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s), .w(w_u),
    .readnum(readnum_u), .writenum(writenum_u), .vsel(vsel_u), .loada(loada_u),
    .loadb(loadb_u), .shift(shift_u), .asel(asel_u), .bsel(bsel_u), .ALUop(ALUop_u),
    .loadc(loadc_u), .loads(loads_u), .write(write_u), .sximm8(sximm8_u),
    .sximm5(sximm5_u), .err(err_u)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] instr);
    in = instr; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_w", w, 1);
    check("rst_write", write, 0);
    check("rst_err", err, 0);
    check("rst_sximm8", sximm8, 16'h0000);
    #11 rst_n = 1'b1;
    tick();
    check("post_rst_w", w, 1);

    // MOV R0,#7
    start(16'hD007);
    check("movi_dec_w", w, 0);
    check("movi_dec_write", write, 0);
    tick();
    check("movi_write", write, 1);
    check("movi_vsel", vsel, 2'b10);
    check("movi_writenum", writenum, 0);
    check("movi_sximm8", sximm8, 16'h0007);
    tick();
    check("movi_done_w", w, 1);
    check("movi_done_write", write, 0);

    // Load without start: IR updates, FSM stays idle
    in = 16'hD0F9; load = 1'b1;
    tick();
    load = 1'b0;
    check("ld_only_w", w, 1);
    check("sximm8_signed", sximm8, 16'hFFF9);
    check("sximm8_zero", sximm8_u, 16'h00F9);
    check("sximm5", sximm5, 16'hFFF9);

    // ADD R2,R1,R0,LSL#1; loads while busy must be ignored
    start(16'hA148);
    in = 16'hFFFF; load = 1'b1;
    check("add_dec_w", w, 0);
    tick();
    check("add_geta_loada", loada, 1);
    check("add_geta_readnum", readnum, 1);
    tick();
    check("add_getb_loadb", loadb, 1);
    check("add_getb_loada", loada, 0);
    check("add_getb_readnum", readnum, 0);
    tick();
    check("add_exec_shift", shift, 2'b01);
    check("add_exec_aluop", ALUop, 2'b00);
    check("add_exec_loadc", loadc, 1);
    check("add_exec_loads", loads, 0);
    check("add_exec_bsel", bsel, 0);
    check("add_exec_asel", asel, 0);
    check("add_exec_write", write, 0);
    tick();
    check("add_wr_write", write, 1);
    check("add_wr_vsel", vsel, 2'b00);
    check("add_wr_writenum", writenum, 2);
    check("add_ir_kept", sximm8, 16'h0048);
    load = 1'b0;
    tick();
    check("add_done_w", w, 1);

    // CMP R1,R0
    start(16'hA900);
    tick();
    check("cmp_geta_readnum", readnum, 1);
    tick();
    check("cmp_getb_loadb", loadb, 1);
    tick();
    check("cmp_exec_loads", loads, 1);
    check("cmp_exec_aluop", ALUop, 2'b01);
    check("cmp_exec_write", write, 0);
    check("cmp_exec_w", w, 0);
    tick();
    check("cmp_done_w", w, 1);
    check("cmp_done_write", write, 0);

    // MVN R7,R3: straight to GET_B
    start(16'hB8E3);
    tick();
    check("mvn_getb_loadb", loadb, 1);
    check("mvn_getb_loada", loada, 0);
    check("mvn_getb_readnum", readnum, 3);
    tick();
    check("mvn_exec_aluop", ALUop, 2'b11);
    tick();
    check("mvn_wr_writenum", writenum, 7);
    tick();

    // MOV R5,R2,LSR#1
    start(16'hC0B2);
    tick();
    check("movr_getb_readnum", readnum, 2);
    tick();
    check("movr_exec_asel", asel, 1);
    check("movr_exec_shift", shift, 2'b10);
    check("movr_exec_aluop", ALUop, 2'b00);
    tick();
    check("movr_wr_writenum", writenum, 5);
    check("movr_wr_write", write, 1);
    tick();
    check("movr_done_w", w, 1);

    // Reset mid-instruction in GET_B, no clock edge needed
    start(16'hA148);
    tick();
    tick();
    check("rstmid_getb_loadb", loadb, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_w", w, 1);
    check("rstmid_loadb", loadb, 0);
    check("rstmid_ir", sximm8, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_hold_write", write, 0);
    end
    #2 rst_n = 1'b1;
    tick();
    check("rstmid_after_w", w, 1);
    check("rstmid_after_write", write, 0);

    // Illegal opcode 111
    start(16'hE000);
    check("ill_dec_w", w, 0);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    tick();
    s = 1'b1; load = 1'b1; in = 16'hD007;
    for (int i = 0; i < 10; i++) begin
      check("ill_halt_w", w, 0);
      check("ill_halt_err", err, 1);
      check("ill_halt_write", write, 0);
      tick();
    end
    s = 1'b0; load = 1'b0;
    rst_n = 1'b0;
    #1;
    check("ill_rst_err", err, 0);
    check("ill_rst_w", w, 1);
    #2 rst_n = 1'b1;
    tick();
`else
    tick();
    check("ill_nop_w", w, 1);
    check("ill_nop_err", err, 0);
    check("ill_nop_write", write, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
